dpi_stream_sequencer: RTL

Front-end sequencer for the DPI regex matcher bank. It accepts byte-wide packets from the packet parser, each tagged with a flow key on its SOP beat, and maps the key to a 6-bit stream id through a 64-entry flow table. It then drives the shared matcher control bus (stream_id, new_stream_id, load_state, char_in, char_in_vld, eop) to every per-regex wrapper. The block spaces load, characters and EOP so that the matchers' registered state restore, DFA and state save pipelines line up.

---
 rtl/dpi_stream_sequencer_if.sv | 21 ++
 rtl/dpi_stream_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_sequencer_if.sv
// rtl/dpi_stream_sequencer_if.sv - packet beat interface from the parser into the DPI stream sequencer
interface dpi_stream_sequencer_if #(
    parameter int KEY_W = 32
) ();
    logic             pkt_vld;
    logic             pkt_sop;
    logic             pkt_eop;
    logic [7:0]       pkt_data;
    logic [KEY_W-1:0] pkt_key;
    logic             pkt_rdy;

    modport master (
        output pkt_vld, pkt_sop, pkt_eop, pkt_data, pkt_key,
        input  pkt_rdy
    );

    modport slave (
        input  pkt_vld, pkt_sop, pkt_eop, pkt_data, pkt_key,
        output pkt_rdy
    );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - flow-table lookup and matcher control bus sequencing for the DPI regex bank
module dpi_stream_sequencer #(
    parameter int KEY_W    = 32,
    parameter int LOAD_GAP = 2,
    parameter int EOP_LAG  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dpi_stream_sequencer_if.slave  pkt,
    input  logic                   tbl_clear,
    output logic [5:0]             stream_id,
    output logic                   new_stream_id,
    output logic                   load_state,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   eop,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_WAIT,
        S_STREAM,
        S_DRAIN
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(LOAD_GAP - 1);
    localparam logic [7:0] LAG_PRE  = 8'(EOP_LAG - 1);
    localparam logic [7:0] LAG_END  = 8'(EOP_LAG);

    state_t           state;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] tbl_key [64];
    logic [63:0]      tbl_vld;
    logic [5:0]       rr_ptr;
    logic             clr_pend;
    logic [7:0]       cnt;

    logic             hit;
    logic [5:0]       hit_idx;
    logic             has_free;
    logic [5:0]       free_idx;
    logic [5:0]       alloc_idx;
    logic             clr_now;
    logic             beat;

    assign pkt.pkt_rdy = (state == S_STREAM) ||
                         (state == S_IDLE && pkt.pkt_vld && !pkt.pkt_sop);
    assign beat      = pkt.pkt_vld && pkt.pkt_rdy;
    // A clear pulse arriving alongside an SOP in IDLE must still win over that lookup.
    assign clr_now   = (state == S_IDLE) && (clr_pend || tbl_clear);
    assign alloc_idx = has_free ? free_idx : rr_ptr;

    // Descending scan so the lowest matching / lowest free index is what remains.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = 6'd0;
        has_free = 1'b0;
        free_idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (tbl_vld[i] && tbl_key[i] == key_q) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
            if (!tbl_vld[i]) begin
                has_free = 1'b1;
                free_idx = 6'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_LOOKUP && !hit) begin
            tbl_key[alloc_idx] <= key_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            key_q         <= '0;
            tbl_vld       <= '0;
            rr_ptr        <= 6'd0;
            clr_pend      <= 1'b0;
            cnt           <= 8'd0;
            stream_id     <= 6'd0;
            new_stream_id <= 1'b0;
            load_state    <= 1'b0;
            char_in       <= 8'd0;
            char_in_vld   <= 1'b0;
            eop           <= 1'b0;
            hit_count     <= 16'd0;
            miss_count    <= 16'd0;
        end else begin
            load_state  <= 1'b0;
            char_in_vld <= 1'b0;
            eop         <= 1'b0;
            clr_pend    <= clr_now ? 1'b0 : (clr_pend | tbl_clear);
            if (clr_now) begin
                tbl_vld <= '0;
                rr_ptr  <= 6'd0;
            end
            case (state)
                S_IDLE: begin
                    if (pkt.pkt_vld && pkt.pkt_sop) begin
                        key_q <= pkt.pkt_key;
                        state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    new_stream_id <= !hit;
                    load_state    <= 1'b1;
                    if (hit) begin
                        stream_id <= hit_idx;
                        hit_count <= hit_count + 16'd1;
                    end else begin
                        stream_id          <= alloc_idx;
                        miss_count         <= miss_count + 16'd1;
                        tbl_vld[alloc_idx] <= 1'b1;
                        if (!has_free) begin
                            rr_ptr <= rr_ptr + 6'd1;
                        end
                    end
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    cnt   <= 8'd0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == GAP_LAST) begin
                        state <= S_STREAM;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_STREAM: begin
                    if (beat) begin
                        char_in     <= pkt.pkt_data;
                        char_in_vld <= 1'b1;
                        if (pkt.pkt_eop) begin
                            cnt   <= 8'd0;
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LAG_PRE) begin
                        eop <= 1'b1;
                    end
                    if (cnt == LAG_END) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
